// File: rtl/display_state.sv
// Plays a latched packed colour sequence back one colour at a time: each colour lit for
// ON_CYCLES, then dark for OFF_CYCLES, then complete_display holds until en drops.
module display_state #(
    parameter int unsigned ON_CYCLES  = 24'd12_000_000,
    parameter int unsigned OFF_CYCLES = 24'd6_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] sequence_val,
    input  logic [3:0]  sequence_len,
    output logic [1:0]  colour_out,
    output logic        colour_on,
    output logic [3:0]  colour_idx,
    output logic        complete_display
);

    localparam int unsigned MaxCycles = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned TimerW    = $clog2(MaxCycles + 1);

    localparam logic [TimerW-1:0] OnLast  = TimerW'(ON_CYCLES - 1);
    localparam logic [TimerW-1:0] OffLast = TimerW'(OFF_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StOn, StOff, StDone} state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [3:0]        idx_q, idx_d;
    logic [31:0]       seq_q, seq_d;
    logic [3:0]        len_q, len_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            timer_q <= '0;
            idx_q   <= '0;
            seq_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        timer_d          = timer_q;
        idx_d            = idx_q;
        seq_d            = seq_q;
        len_d            = len_q;
        colour_on        = 1'b0;
        colour_out       = 2'b00;
        complete_display = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (en) begin
                    seq_d   = sequence_val;
                    len_d   = sequence_len;
                    idx_d   = '0;
                    timer_d = '0;
                    state_d = (sequence_len != 4'd0) ? StOn : StDone;
                end
            end
            StOn: begin
                colour_on  = 1'b1;
                colour_out = seq_q[{idx_q, 1'b0} +: 2];
                if (timer_q == OnLast) begin
                    timer_d = '0;
                    state_d = StOff;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StOff: begin
                if (timer_q == OffLast) begin
                    timer_d = '0;
                    if (idx_q == len_q - 4'd1) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = StOn;
                    end
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StDone: begin
                complete_display = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // Dropping en aborts from any active state; idx is cleared so IDLE shows all zeros.
        if (state_q != StIdle && !en) begin
            state_d = StIdle;
            idx_d   = '0;
            timer_d = '0;
        end
    end

    assign colour_idx = idx_q;

endmodule
